// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit CPU control path.
// Holds the opcode map, the control-word bit layout, the micro-step count
// and a small helper that builds one-hot control bits by name.
package cpu_pkg;

    // Control-word width and micro-steps per instruction (T0..T4).
    localparam int CW    = 16;
    localparam int STEPS = 5;

    // Opcode map (IR[7:4]); 0x9..0xD are undefined and behave as NOP.
    localparam logic [3:0] OP_NOP = 4'h0;
    localparam logic [3:0] OP_LDA = 4'h1;
    localparam logic [3:0] OP_ADD = 4'h2;
    localparam logic [3:0] OP_SUB = 4'h3;
    localparam logic [3:0] OP_STA = 4'h4;
    localparam logic [3:0] OP_LDI = 4'h5;
    localparam logic [3:0] OP_JMP = 4'h6;
    localparam logic [3:0] OP_JC  = 4'h7;
    localparam logic [3:0] OP_JZ  = 4'h8;
    localparam logic [3:0] OP_OUT = 4'hE;
    localparam logic [3:0] OP_HLT = 4'hF;

    // Control-word bit positions, MSB first:
    // {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi}
    localparam int CB_HLT = 15;  // halt clock
    localparam int CB_MI  = 14;  // MAR in
    localparam int CB_RI  = 13;  // RAM in
    localparam int CB_RO  = 12;  // RAM out
    localparam int CB_IO  = 11;  // IR operand out
    localparam int CB_II  = 10;  // IR in
    localparam int CB_AI  = 9;   // A in
    localparam int CB_AO  = 8;   // A out
    localparam int CB_EO  = 7;   // ALU out
    localparam int CB_SU  = 6;   // ALU subtract
    localparam int CB_BI  = 5;   // B in
    localparam int CB_OI  = 4;   // OUT register in
    localparam int CB_CE  = 3;   // PC count enable
    localparam int CB_CO  = 2;   // PC out
    localparam int CB_J   = 1;   // PC load (jump)
    localparam int CB_FI  = 0;   // flags in

    // Sequencer run mode: stepping normally, or stopped by HLT until clr.
    typedef enum logic {
        MODE_RUN    = 1'b0,
        MODE_HALTED = 1'b1
    } mode_t;

    // One-hot control word with only bit 'idx' set; lets the microcode read
    // as a list of named signals instead of hex constants.
    function automatic logic [CW-1:0] cb(input int idx);
        logic [CW-1:0] one;
        one = {{(CW-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Sequencer-facing bundle: the run/decode inputs coming from the CPU
// datapath and the control word, step and halt status going back to it.
// 'master' is the CPU/datapath side, 'slave' is the sequencer.
interface control_sequencer_if #(
    parameter int CW = cpu_pkg::CW
);
    logic          run;
    logic [3:0]    opcode;
    logic          carry;
    logic          zero;
    logic [CW-1:0] ctrl;
    logic [2:0]    step;
    logic          halted;

    modport master (
        output run,
        output opcode,
        output carry,
        output zero,
        input  ctrl,
        input  step,
        input  halted
    );

    modport slave (
        input  run,
        input  opcode,
        input  carry,
        input  zero,
        output ctrl,
        output step,
        output halted
    );

endinterface

// File: rtl/microcode_rom.sv
// Combinational microcode: (opcode, step, carry, zero) -> control word and
// an end-of-instruction flag. Holds no state.
// Optional feature: SEQ_EARLY_END_EN -- when defined, 'last' marks each
// instruction's final useful step so the sequencer returns to T0 early;
// when undefined, 'last' is only asserted at T4 and every instruction
// takes the full five steps.
module microcode_rom
    import cpu_pkg::*;
(
    input  logic [3:0]    opcode,
    input  logic [2:0]    step,
    input  logic          carry,
    input  logic          zero,
    output logic [CW-1:0] ctrl,
    output logic          last
);

    // Decode the control word for the current step; fetch is shared by all
    // opcodes, execute steps depend on the opcode and, for JC/JZ, the flags.
    // NOTE: every output of an always_comb gets a default on entry, so any
    // path that does not assign it falls back to 0 instead of inferring a latch.
    always_comb begin
        ctrl = '0;
        case (step)
            3'd0: ctrl = cb(CB_CO) | cb(CB_MI);
            3'd1: ctrl = cb(CB_RO) | cb(CB_II) | cb(CB_CE);
            3'd2: begin
                case (opcode)
                    OP_LDA, OP_ADD, OP_SUB, OP_STA:
                        ctrl = cb(CB_IO) | cb(CB_MI);
                    OP_LDI: ctrl = cb(CB_IO) | cb(CB_AI);
                    OP_JMP: ctrl = cb(CB_IO) | cb(CB_J);
                    OP_JC:  if (carry) ctrl = cb(CB_IO) | cb(CB_J);
                    OP_JZ:  if (zero)  ctrl = cb(CB_IO) | cb(CB_J);
                    OP_OUT: ctrl = cb(CB_AO) | cb(CB_OI);
                    OP_HLT: ctrl = cb(CB_HLT);
                    default: ctrl = '0;
                endcase
            end
            3'd3: begin
                case (opcode)
                    OP_LDA:         ctrl = cb(CB_RO) | cb(CB_AI);
                    OP_ADD, OP_SUB: ctrl = cb(CB_RO) | cb(CB_BI);
                    OP_STA:         ctrl = cb(CB_AO) | cb(CB_RI);
                    default:        ctrl = '0;
                endcase
            end
            3'd4: begin
                case (opcode)
                    OP_ADD:  ctrl = cb(CB_EO) | cb(CB_AI) | cb(CB_FI);
                    OP_SUB:  ctrl = cb(CB_EO) | cb(CB_AI) | cb(CB_FI) | cb(CB_SU);
                    default: ctrl = '0;
                endcase
            end
            default: ctrl = '0;
        endcase
    end

`ifdef SEQ_EARLY_END_EN
    // Flag the last non-zero step of each instruction so the next step is T0.
    always_comb begin
        last = 1'b0;
        case (opcode)
            OP_ADD, OP_SUB: last = (step == 3'(STEPS - 1));
            OP_LDA, OP_STA: last = (step == 3'd3);
            default:        last = (step == 3'd2);
        endcase
    end
`else
    // Fixed-length instructions: only the final step ends the instruction.
    assign last = (step == 3'(STEPS - 1));
`endif

endmodule

// File: rtl/control_sequencer.sv
// Microcode sequencer for the 8-bit CPU. Owns the micro-step counter and
// the halt state, both updated on the falling edge of clk so the decoded
// control word is stable for the whole clk-high phase in which the
// downstream registers capture. The control word is gated to zero during
// reset, pause (run=0) and halt.
// Optional feature: SEQ_EARLY_END_EN (see microcode_rom) shortens
// instructions by returning to T0 after their last useful step.
module control_sequencer
    import cpu_pkg::*;
(
    input  logic                clk,
    input  logic                clr,
    control_sequencer_if.slave  bus
);

    logic [2:0]    step_q;
    logic [2:0]    step_d;
    mode_t         mode_q;
    mode_t         mode_d;
    logic [CW-1:0] rom_ctrl;
    logic          rom_last;
    logic          active;

    microcode_rom u_rom (
        .opcode (bus.opcode),
        .step   (step_q),
        .carry  (bus.carry),
        .zero   (bus.zero),
        .ctrl   (rom_ctrl),
        .last   (rom_last)
    );

    // The sequencer only advances, and the control word is only passed
    // through, when out of reset, enabled and not halted.
    assign active = clr && bus.run && (mode_q == MODE_RUN);

    // State register: falling-edge update with synchronous active-low clear.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of statement order.
    always_ff @(negedge clk) begin
        if (!clr) begin
            step_q <= '0;
            mode_q <= MODE_RUN;
        end else begin
            step_q <= step_d;
            mode_q <= mode_d;
        end
    end

    // Next-state: hold unless active; HLT freezes the step at T2 and enters
    // the halted mode, otherwise wrap at end of instruction or increment.
    always_comb begin
        step_d = step_q;
        mode_d = mode_q;
        if (active) begin
            if (rom_ctrl[CB_HLT]) begin
                mode_d = MODE_HALTED;
            end else if (rom_last || (step_q >= 3'(STEPS - 1))) begin
                step_d = '0;
            end else begin
                step_d = step_q + 3'd1;
            end
        end
    end

    // Combinational gating so no register write can happen in reset, pause
    // or halt, even within the current clk-high phase.
    assign bus.ctrl   = active ? rom_ctrl : '0;
    assign bus.step   = step_q;
    assign bus.halted = (mode_q == MODE_HALTED);

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench for control_sequencer. The stimulus process drives
// inputs just after each falling edge and queues the expected
// {ctrl, step, halted} for the following clk-high phase; a monitor pops
// and compares on every rising edge while the queue holds entries.
// Builds with or without SEQ_EARLY_END_EN.
module tb_control_sequencer;
    import cpu_pkg::*;

`ifdef SEQ_EARLY_END_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    // Hand-computed control words (bit order hlt,mi,ri,ro,io,ii,ai,ao,eo,su,bi,oi,ce,co,j,fi).
    localparam logic [15:0] W_FETCH0 = 16'h4004;  // co|mi
    localparam logic [15:0] W_FETCH1 = 16'h1408;  // ro|ii|ce
    localparam logic [15:0] W_IO_MI  = 16'h4800;  // io|mi
    localparam logic [15:0] W_RO_AI  = 16'h1200;  // ro|ai
    localparam logic [15:0] W_RO_BI  = 16'h1020;  // ro|bi
    localparam logic [15:0] W_ADD4   = 16'h0281;  // eo|ai|fi
    localparam logic [15:0] W_SUB4   = 16'h02C1;  // eo|ai|fi|su
    localparam logic [15:0] W_STA3   = 16'h2100;  // ao|ri
    localparam logic [15:0] W_JUMP   = 16'h0802;  // io|j
    localparam logic [15:0] W_LDI    = 16'h0A00;  // io|ai
    localparam logic [15:0] W_OUT    = 16'h0110;  // ao|oi
    localparam logic [15:0] W_HLT    = 16'h8000;  // hlt

    logic clk = 1'b1;
    logic clr;

    control_sequencer_if bus ();

    control_sequencer dut (
        .clk (clk),
        .clr (clr),
        .bus (bus)
    );

    always #5 clk = ~clk;

    logic [19:0] exp_q[$];
    string       name_q[$];
    int          vectors     = 0;
    int          miscompares = 0;

    // Monitor: compare DUT outputs in the clk-high phase against the queue.
    always @(posedge clk) begin
        logic [19:0] e;
        string       n;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            n = name_q.pop_front();
            vectors++;
            if ({bus.ctrl, bus.step, bus.halted} !== e) begin
                miscompares++;
                $display("FAIL %s: got ctrl=%h step=%0d halted=%b, expected ctrl=%h step=%0d halted=%b",
                         n, bus.ctrl, bus.step, bus.halted, e[19:4], e[3:1], e[0]);
            end
        end
    end

    // Queue one expected high-phase result, then move to the next cycle.
    task automatic expect_cycle(input string name, input logic [15:0] c,
                                input logic [2:0] s, input logic h);
        exp_q.push_back({c, s, h});
        name_q.push_back(name);
        @(negedge clk);
        #1;
    endtask

    // Run one full instruction from T0, expecting the given execute words
    // and ending at 'last_step' with early end, otherwise at T4.
    task automatic run_instr(input string name, input logic [3:0] op,
                             input logic [15:0] w2, input logic [15:0] w3,
                             input logic [15:0] w4, input int last_step);
        logic [15:0] w[5];
        int          stop;
        w[0] = W_FETCH0;
        w[1] = W_FETCH1;
        w[2] = w2;
        w[3] = w3;
        w[4] = w4;
        stop = EARLY ? last_step : 4;
        bus.opcode = op;
        for (int t = 0; t <= stop; t++)
            expect_cycle($sformatf("%s_t%0d", name, t), w[t], 3'(t), 1'b0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        clr        = 1'b0;
        bus.run    = 1'b1;
        bus.opcode = OP_LDA;
        bus.carry  = 1'b0;
        bus.zero   = 1'b0;
        @(negedge clk);
        #1;

        // Reset held for two cycles: outputs gated, step at 0.
        expect_cycle("reset_0", 16'h0000, 3'd0, 1'b0);
        expect_cycle("reset_1", 16'h0000, 3'd0, 1'b0);
        clr = 1'b1;

        // Main instruction set; each call's T0 also checks the previous wrap.
        run_instr("lda",   OP_LDA, W_IO_MI, W_RO_AI, 16'h0000, 3);
        run_instr("add",   OP_ADD, W_IO_MI, W_RO_BI, W_ADD4,   4);
        run_instr("sub",   OP_SUB, W_IO_MI, W_RO_BI, W_SUB4,   4);
        bus.carry = 1'b0;
        run_instr("jc_nc", OP_JC,  16'h0000, 16'h0000, 16'h0000, 2);
        bus.carry = 1'b1;
        run_instr("jc_c",  OP_JC,  W_JUMP,   16'h0000, 16'h0000, 2);
        bus.carry = 1'b0;
        bus.zero  = 1'b1;
        run_instr("jz_z",  OP_JZ,  W_JUMP,   16'h0000, 16'h0000, 2);
        bus.zero  = 1'b0;
        run_instr("jz_nz", OP_JZ,  16'h0000, 16'h0000, 16'h0000, 2);
        run_instr("ldi",   OP_LDI, W_LDI,    16'h0000, 16'h0000, 2);
        run_instr("jmp",   OP_JMP, W_JUMP,   16'h0000, 16'h0000, 2);
        run_instr("out",   OP_OUT, W_OUT,    16'h0000, 16'h0000, 2);
        run_instr("nop",   OP_NOP, 16'h0000, 16'h0000, 16'h0000, 2);
        run_instr("undef", 4'hB,   16'h0000, 16'h0000, 16'h0000, 2);

        // STA paused at T2 for three cycles, then resumed at the same step.
        bus.opcode = OP_STA;
        expect_cycle("sta_t0", W_FETCH0, 3'd0, 1'b0);
        expect_cycle("sta_t1", W_FETCH1, 3'd1, 1'b0);
        bus.run = 1'b0;
        for (int i = 0; i < 3; i++)
            expect_cycle($sformatf("sta_pause_%0d", i), 16'h0000, 3'd2, 1'b0);
        bus.run = 1'b1;
        expect_cycle("sta_resume_t2", W_IO_MI, 3'd2, 1'b0);
        expect_cycle("sta_t3", W_STA3, 3'd3, 1'b0);
        if (!EARLY)
            expect_cycle("sta_t4", 16'h0000, 3'd4, 1'b0);

        // ADD aborted by clr at T3: gated immediately, step cleared next edge.
        bus.opcode = OP_ADD;
        expect_cycle("add_abort_t0", W_FETCH0, 3'd0, 1'b0);
        expect_cycle("add_abort_t1", W_FETCH1, 3'd1, 1'b0);
        expect_cycle("add_abort_t2", W_IO_MI,  3'd2, 1'b0);
        clr = 1'b0;
        expect_cycle("add_abort_t3", 16'h0000, 3'd3, 1'b0);
        expect_cycle("add_abort_rst", 16'h0000, 3'd0, 1'b0);
        clr = 1'b1;

        // HLT: stops after T2 and stays halted until a clr pulse.
        bus.opcode = OP_HLT;
        expect_cycle("hlt_t0", W_FETCH0, 3'd0, 1'b0);
        expect_cycle("hlt_t1", W_FETCH1, 3'd1, 1'b0);
        expect_cycle("hlt_t2", W_HLT,    3'd2, 1'b0);
        for (int i = 0; i < 20; i++)
            expect_cycle($sformatf("halted_%0d", i), 16'h0000, 3'd2, 1'b1);
        clr = 1'b0;
        expect_cycle("halt_clr", 16'h0000, 3'd2, 1'b1);
        clr = 1'b1;
        expect_cycle("post_halt_t0", W_FETCH0, 3'd0, 1'b0);
        bus.opcode = OP_LDA;
        expect_cycle("post_halt_t1", W_FETCH1, 3'd1, 1'b0);

        // Let the monitor drain the queue, bounded.
        for (int i = 0; i < 10 && exp_q.size() > 0; i++)
            @(negedge clk);
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending vectors, expected 0", exp_q.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
